// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared definitions for the sequential multiplier: FSM state
//               encoding and the helper that sizes the iteration counter.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Controller states. IDLE waits for a request, BUSY iterates the
  // shift-add datapath, DONE presents the finished product.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The iteration counter must be able to hold the value WIDTH itself,
  // since that value is what ends the iteration phase.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult
// Description : Sequential shift-add multiplier, one partial product per
//               clock. Signed operands are reduced to magnitudes when they
//               are latched, multiplied unsigned, and the result is negated
//               on completion when the operand signs differ.
// Revision    : 1.0 - initial release
//
// Parameters
//   WIDTH          operand width in bits (4..64)
//   SIGNED_DEFAULT reset value of the latched signed-mode flag
//
// Ports
//   clk          in   1        clock, rising edge
//   resetn       in   1        asynchronous active-low reset
//   mult_begin   in   1        level request; starts and holds an operation
//   mult_signed  in   1        1 = two's-complement operands
//   mult_op1     in   WIDTH    multiplicand
//   mult_op2     in   WIDTH    multiplier
//   product      out  2*WIDTH  registered result
//   mult_end     out  1        high while product holds a completed result
//   mult_busy    out  1        high while iterating
//
// Build option
//   SEQ_MULT_EARLY_EXIT_EN  when defined, iteration stops as soon as the
//                           remaining multiplier bits are all zero (at least
//                           one iteration is always performed). Results are
//                           identical; only latency changes.
// ============================================================================
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter bit SIGNED_DEFAULT = 1'b0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 mult_begin,
  input  logic                 mult_signed,
  input  logic [WIDTH-1:0]     mult_op1,
  input  logic [WIDTH-1:0]     mult_op2,
  output logic [2*WIDTH-1:0]   product,
  output logic                 mult_end,
  output logic                 mult_busy
);

  localparam int              CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] OP_ONE  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] PROD_ONE = (2*WIDTH)'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t               state;
  state_t               next_state;

  logic [2*WIDTH-1:0]   mcand;        // multiplicand magnitude, shifted left each step
  logic [WIDTH-1:0]     mplier;       // remaining multiplier magnitude bits
  logic [2*WIDTH-1:0]   acc;          // running sum of partial products
  logic [CW-1:0]        cnt;          // iterations performed so far
  logic                 signed_flag;  // operand mode captured at latch
  logic                 sign_diff;    // operand sign bits differed at latch

  // --------------------------------------------------------------------------
  // Operand magnitudes. In signed mode a negative operand is negated; the
  // most-negative value negates to itself, which read as unsigned is exactly
  // 2^(WIDTH-1), so no extra bit is required.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] op1_mag;
  logic [WIDTH-1:0] op2_mag;

  always_comb begin
    op1_mag = mult_op1;
    op2_mag = mult_op2;
    if (mult_signed && mult_op1[WIDTH-1]) begin
      op1_mag = ~mult_op1 + OP_ONE;
    end
    if (mult_signed && mult_op2[WIDTH-1]) begin
      op2_mag = ~mult_op2 + OP_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // End-of-iteration condition
  // --------------------------------------------------------------------------
  logic iter_done;

`ifdef SEQ_MULT_EARLY_EXIT_EN
  // After at least one step, further steps with an all-zero multiplier
  // would add nothing, so finish immediately.
  always_comb begin
    iter_done = ((cnt != '0) && (mplier == '0)) || (cnt == CNT_LAST);
  end
`else
  always_comb begin
    iter_done = (cnt == CNT_LAST);
  end
`endif

  // --------------------------------------------------------------------------
  // Final result: magnitude product, negated when signs differed
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] acc_final;

  always_comb begin
    acc_final = acc;
    if (signed_flag && sign_diff) begin
      acc_final = ~acc + PROD_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. Dropping mult_begin takes priority in BUSY so that an
  // abort on the final iteration edge still leaves product untouched.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (mult_begin) begin
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (!mult_begin) begin
          next_state = IDLE;
        end else if (iter_done) begin
          next_state = DONE;
        end
      end
      DONE: begin
        // Leaving DONE only through IDLE with mult_begin low guarantees a
        // held request can never restart the multiplier.
        if (!mult_begin) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      sign_diff   <= 1'b0;
      signed_flag <= SIGNED_DEFAULT;
      product     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mult_begin) begin
            mcand       <= {{WIDTH{1'b0}}, op1_mag};
            mplier      <= op2_mag;
            acc         <= '0;
            cnt         <= '0;
            signed_flag <= mult_signed;
            sign_diff   <= mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1];
          end
        end
        BUSY: begin
          if (mult_begin) begin
            if (iter_done) begin
              product <= acc_final;
            end else begin
              if (mplier[0]) begin
                acc <= acc + mcand;
              end
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
              cnt    <= cnt + 1'b1;
            end
          end
        end
        default: begin
          // DONE: hold everything; product stays until the next completion.
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Status outputs, decoded straight from the state register
  // --------------------------------------------------------------------------
  always_comb begin
    mult_end  = (state == DONE);
    mult_busy = (state == BUSY);
  end

endmodule : seq_mult
`default_nettype wire

// File: tb/tb_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mult
// Description : Scoreboard bench for seq_mult (WIDTH=32). The driver pushes
//               the expected product and completion cycle when an operation
//               is latched; a monitor pops and compares on each mult_end
//               rising.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult;

  localparam int W = 32;

  logic             clk;
  logic             resetn;
  logic             mult_begin;
  logic             mult_signed;
  logic [W-1:0]     mult_op1;
  logic [W-1:0]     mult_op2;
  logic [2*W-1:0]   product;
  logic             mult_end;
  logic             mult_busy;

  seq_mult #(.WIDTH(W), .SIGNED_DEFAULT(1'b0)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .mult_begin (mult_begin),
    .mult_signed(mult_signed),
    .mult_op1   (mult_op1),
    .mult_op2   (mult_op2),
    .product    (product),
    .mult_end   (mult_end),
    .mult_busy  (mult_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] prod;
    int             end_cyc;
  } exp_t;

  exp_t exp_q[$];

  int total  = 0;
  int passed = 0;
  logic [2*W-1:0] last_prod = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected latency from latching edge to mult_end.
  function automatic int latency(input logic [W-1:0] op2, input logic sgn);
    logic [W-1:0] m;
    int n;
    m = (sgn && op2[W-1]) ? (~op2 + 32'd1) : op2;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    return n + 1;
`else
    m = m;
    n = W;
    return n + 1;
`endif
  endfunction

  // Monitor: compare on each rising mult_end.
  logic prev_end = 1'b0;
  always @(negedge clk) begin
    if (resetn && mult_end && !prev_end) begin
      if (exp_q.size() == 0) begin
        check("unexpected_end", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("product", product, e.prod);
        check("end_cycle", 64'(cyc), 64'(e.end_cyc));
      end
    end
    prev_end <= mult_end;
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input logic [2*W-1:0] exp_p);
    exp_t e;
    int n;
    @(negedge clk);
    mult_op1 = a; mult_op2 = b; mult_signed = sgn; mult_begin = 1'b1;
    @(posedge clk);
    #1;
    e.prod = exp_p;
    e.end_cyc = cyc + latency(b, sgn);
    exp_q.push_back(e);
    // Operand changes during the operation must be ignored.
    mult_op1 = ~a; mult_op2 = b ^ 32'h5A5A_A5A5; mult_signed = ~sgn;
    n = 0;
    while (!mult_end && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(mult_end), 64'd1);
    // Holding the request keeps DONE and must not restart.
    repeat (3) @(negedge clk);
    check("done_hold", 64'(mult_end), 64'd1);
    check("no_restart", 64'(mult_busy), 64'd0);
    check("product_hold", product, exp_p);
    mult_begin = 1'b0;
    @(negedge clk);
    check("end_fall", 64'(mult_end), 64'd0);
    last_prod = exp_p;
  endtask

  initial begin
    resetn = 1'b0; mult_begin = 1'b0; mult_signed = 1'b0;
    mult_op1 = '0; mult_op2 = '0;
    repeat (3) @(negedge clk);
    check("rst_product", product, 64'd0);
    check("rst_end", 64'(mult_end), 64'd0);
    check("rst_busy", 64'(mult_busy), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    run_op(32'h0000_1111, 32'h0000_1111, 1'b0, 64'h0000_0000_0123_4321);
    run_op(32'h0000_1111, 32'h0000_2222, 1'b0, 64'h0000_0000_0246_8642);
    run_op(32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 64'h0000_0001_FFFF_FFFE);
    run_op(32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(32'h0000_0002, 32'h8000_0000, 1'b0, 64'h0000_0001_0000_0000);
    run_op(32'h0000_0002, 32'h8000_0000, 1'b1, 64'hFFFF_FFFF_0000_0000);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    run_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 64'h0000_0000_0000_000F);
    run_op(32'h1234_5678, 32'h0000_0000, 1'b0, 64'h0000_0000_0000_0000);

    // Abort at BUSY cycle 10: back to IDLE, no mult_end, product unchanged.
    run_op(32'h0000_0007, 32'h0000_0006, 1'b0, 64'h0000_0000_0000_002A);
    @(negedge clk);
    mult_op1 = 32'h0000_FFFF; mult_op2 = 32'h0000_FFFF; mult_begin = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    mult_begin = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 64'(mult_busy), 64'd0);
    begin
      logic saw_end;
      saw_end = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (mult_end) saw_end = 1'b1;
      end
      check("abort_no_end", 64'(saw_end), 64'd0);
    end
    check("abort_product", product, last_prod);

    // Reset mid-BUSY clears all outputs without waiting for a clock edge.
    @(negedge clk);
    mult_op1 = 32'h0000_0009; mult_op2 = 32'h0000_0009; mult_begin = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("arst_product", product, 64'd0);
    check("arst_busy", 64'(mult_busy), 64'd0);
    check("arst_end", 64'(mult_end), 64'd0);
    @(negedge clk);
    mult_begin = 1'b0;
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 64'(mult_busy), 64'd0);
    check("post_rst_product", product, 64'd0);

    run_op(32'h0000_0003, 32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule : tb_seq_mult
`default_nettype wire
